noc_port_arbiter: RTL and testbench

- Output-port arbiter for the 5-port NoC router. One instance sits in front of each output port.
- Shares the output between the five input Fifo_buffer instances using round-robin, with wormhole packet locking.
- Issues one-cycle RD pulses to the granted FIFO, captures the flit that the FIFO returns, and forwards it downstream with a valid strobe.
- Honours downstream backpressure.

---
 rtl/noc_port_arbiter.sv | 130 +++++++++++++
 tb/tb_noc_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/noc_port_arbiter.sv
// Output-port arbiter: round-robin across input FIFOs with wormhole locking.
// Issues RD pulses, captures the returned flit and forwards it downstream.
module noc_port_arbiter #(
    parameter int NPORT = 5,
    parameter int W     = 16,
    parameter int GW    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORT-1:0]     req,
    input  logic [NPORT*W-1:0]   data_in,
    output logic [NPORT-1:0]     rd,
    input  logic                 dn_full,
    output logic [W-1:0]         out_flit,
    output logic                 out_valid,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 proto_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, LOCK} state_t;

    state_t               state, next_state;
    logic [GW-1:0]        rr_ptr, rr_ptr_d;
    logic [GW-1:0]        winner, grant_d;
    logic [GW:0]          scan_sum;
    logic [2*NPORT-1:0]   rot;
    logic                 found;
    logic                 first, first_d;
    logic                 req_g;
    logic [W-1:0]         cap, out_flit_d;
    logic [NPORT-1:0]     rd_d;
    logic                 out_valid_d, proto_err_d;

    // Rotate requests so bit 0 is rr_ptr, then take the first set bit.
    always_comb begin
        rot      = {req, req} >> rr_ptr;
        winner   = '0;
        found    = 1'b0;
        scan_sum = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (!found && rot[k]) begin
                found    = 1'b1;
                scan_sum = {1'b0, rr_ptr} + (GW+1)'(k);
                if (scan_sum >= (GW+1)'(NPORT))
                    scan_sum = scan_sum - (GW+1)'(NPORT);
                winner   = scan_sum[GW-1:0];
            end
        end
    end

    always_comb begin
        req_g = 1'b0;
        cap   = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (grant_id == GW'(i)) begin
                req_g = req[i];
                cap   = data_in[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd        <= '0;
            out_flit  <= '0;
            out_valid <= 1'b0;
            grant_id  <= '0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
            rr_ptr    <= '0;
            first     <= 1'b1;
        end else begin
            state     <= next_state;
            rd        <= rd_d;
            out_flit  <= out_flit_d;
            out_valid <= out_valid_d;
            grant_id  <= grant_d;
            busy      <= (next_state != IDLE);
            proto_err <= proto_err_d;
            rr_ptr    <= rr_ptr_d;
            first     <= first_d;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (found && !dn_full) next_state = ISSUE;
            ISSUE:   next_state = CAPT;
            CAPT:    next_state = cap[W-2] ? IDLE : LOCK;
            LOCK:    if (req_g && !dn_full) next_state = ISSUE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        grant_d     = grant_id;
        first_d     = first;
        rr_ptr_d    = rr_ptr;
        out_flit_d  = out_flit;
        out_valid_d = 1'b0;
        proto_err_d = 1'b0;
        rd_d        = '0;
        unique case (state)
            IDLE: begin
                if (next_state == ISSUE) begin
                    grant_d = winner;
                    first_d = 1'b1;
                end
            end
            CAPT: begin
                out_flit_d  = cap;
                out_valid_d = 1'b1;
                proto_err_d = first ^ cap[W-1];
                first_d     = 1'b0;
                // Pointer only advances once the whole packet has gone.
                if (cap[W-2])
                    rr_ptr_d = (grant_id == GW'(NPORT-1)) ? '0
                                                          : grant_id + 1'b1;
            end
            default: ;
        endcase
        if (next_state == ISSUE)
            for (int i = 0; i < NPORT; i++)
                rd_d[i] = (grant_d == GW'(i));
    end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed vector bench for noc_port_arbiter.
// Each vector: inputs for one cycle, outputs expected after that edge.
module tb_noc_port_arbiter;

    localparam int NPORT = 5;
    localparam int W     = 16;
    localparam int GW    = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NPORT-1:0]     req;
    logic [NPORT*W-1:0]   data_in;
    logic [NPORT-1:0]     rd;
    logic                 dn_full;
    logic [W-1:0]         out_flit;
    logic                 out_valid;
    logic [GW-1:0]        grant_id;
    logic                 busy;
    logic                 proto_err;

    always #5 clk = ~clk;

    noc_port_arbiter #(.NPORT(NPORT), .W(W), .GW(GW)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .rd(rd),
        .dn_full(dn_full), .out_flit(out_flit), .out_valid(out_valid),
        .grant_id(grant_id), .busy(busy), .proto_err(proto_err)
    );

    typedef struct {
        logic [4:0]  req;
        logic        full;
        logic [79:0] din;
        logic [4:0]  rd;
        logic        ov;
        logic [15:0] flit;
        logic [2:0]  gid;
        logic        busy;
        logic        perr;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [79:0] d5(input logic [15:0] a4, a3, a2,
                                       a1, a0);
        return {a4, a3, a2, a1, a0};
    endfunction

    function automatic void add(input logic [4:0] rq, input logic f,
                                input logic [79:0] d, input logic [4:0] r,
                                input logic ov, input logic [15:0] fl,
                                input logic [2:0] g, input logic b,
                                input logic pe);
        vec_t v;
        v.req = rq; v.full = f; v.din = d; v.rd = r; v.ov = ov;
        v.flit = fl; v.gid = g; v.busy = b; v.perr = pe;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h want %0h",
                     name, idx, got, want);
        end
    endtask

    task automatic chk_all(input int idx, input logic [4:0] r,
                           input logic ov, input logic [15:0] fl,
                           input logic [2:0] g, input logic b,
                           input logic pe);
        chk("rd", idx, 32'(rd), 32'(r));
        chk("out_valid", idx, 32'(out_valid), 32'(ov));
        chk("out_flit", idx, 32'(out_flit), 32'(fl));
        chk("grant_id", idx, 32'(grant_id), 32'(g));
        chk("busy", idx, 32'(busy), 32'(b));
        chk("proto_err", idx, 32'(proto_err), 32'(pe));
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            req     = tbl[i].req;
            dn_full = tbl[i].full;
            data_in = tbl[i].din;
            @(posedge clk);
            @(negedge clk);
            chk_all(i, tbl[i].rd, tbl[i].ov, tbl[i].flit, tbl[i].gid,
                    tbl[i].busy, tbl[i].perr);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req     = '0;
        dn_full = 1'b0;
        data_in = '0;
        repeat (2) @(negedge clk);
        chk_all(-1, 5'b0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    int sa, sb, sc, sd, se, sf, send;
    logic [15:0] prev;
    int order [7] = '{0, 1, 2, 3, 4, 0, 1};

    initial begin
        logic [79:0] sgl, pkt, rrd;
        sgl = d5(16'hC004, 16'hC003, 16'hC123, 16'hC001, 16'hC000);
        pkt = d5(16'hC004, 16'hC003, 16'h8001, 16'hC001, 16'hC000);
        rrd = d5(16'hC004, 16'hC003, 16'hC002, 16'hC001, 16'hC000);

        // single flit on port 2, then scan resumes at port 3
        sa = tbl.size();
        add(5'b00100, 0, sgl, 5'b00100, 0, 16'h0000, 2, 1, 0);
        add(5'b00100, 0, sgl, 5'b00000, 0, 16'h0000, 2, 1, 0);
        add(5'b00000, 0, sgl, 5'b00000, 1, 16'hC123, 2, 0, 0);
        add(5'b11111, 0, sgl, 5'b01000, 0, 16'hC123, 3, 1, 0);
        add(5'b11111, 0, sgl, 5'b00000, 0, 16'hC123, 3, 1, 0);
        add(5'b10111, 0, sgl, 5'b00000, 1, 16'hC003, 3, 0, 0);
        add(5'b00100, 0, pkt, 5'b00100, 0, 16'hC003, 2, 1, 0);
        add(5'b00100, 0, pkt, 5'b00000, 0, 16'hC003, 2, 1, 0);
        add(5'b00000, 0, pkt, 5'b00000, 1, 16'h8001, 2, 1, 0);
        add(5'b00000, 0, pkt, 5'b00000, 0, 16'h8001, 2, 1, 0);

        // after async reset: pointer back at 0
        sb = tbl.size();
        add(5'b10001, 0, rrd, 5'b00001, 0, 16'h0000, 0, 1, 0);
        add(5'b10001, 0, rrd, 5'b00000, 0, 16'h0000, 0, 1, 0);
        add(5'b10001, 0, rrd, 5'b00000, 1, 16'hC000, 0, 0, 0);
        add(5'b10001, 0, rrd, 5'b10000, 0, 16'hC000, 4, 1, 0);

        // round robin with all requesting
        sc = tbl.size();
        prev = 16'h0000;
        for (int j = 0; j < 7; j++) begin
            add(5'b11111, 0, rrd, 5'b00001 << order[j], 0, prev,
                3'(order[j]), 1, 0);
            add(5'b11111, 0, rrd, 5'b00000, 0, prev, 3'(order[j]), 1, 0);
            prev = 16'hC000 | 16'(order[j]);
            add(5'b11111, 0, rrd, 5'b00000, 1, prev, 3'(order[j]), 0, 0);
        end

        // three-flit packet on port 0 with ports 1,2 contending
        sd = tbl.size();
        for (int j = 0; j < 3; j++) begin
            logic [15:0] f, p;
            logic [79:0] d;
            f = (j == 0) ? 16'h8001 : (j == 1) ? 16'h0002 : 16'h4003;
            p = (j == 0) ? 16'h0000 : (j == 1) ? 16'h8001 : 16'h0002;
            d = d5(16'hC444, 16'hC333, 16'hC222, 16'hC111, f);
            add(5'b00111, 0, d, 5'b00001, 0, p, 0, 1, 0);
            add(5'b00111, 0, d, 5'b00000, 0, p, 0, 1, 0);
            add(5'b00111, 0, d, 5'b00000, 1, f, 0, (j != 2), 0);
        end
        add(5'b00110, 0, d5(16'hC444, 16'hC333, 16'hC222, 16'hC111, 0),
            5'b00010, 0, 16'h4003, 1, 1, 0);

        // backpressure in IDLE and in LOCK
        se = tbl.size();
        add(5'b00001, 1, d5(0, 0, 0, 0, 16'h8001), 5'b0, 0, 0, 0, 0, 0);
        add(5'b00001, 0, d5(0, 0, 0, 0, 16'h8001), 5'b1, 0, 0, 0, 1, 0);
        add(5'b00001, 0, d5(0, 0, 0, 0, 16'h8001), 5'b0, 0, 0, 0, 1, 0);
        add(5'b00001, 0, d5(0, 0, 0, 0, 16'h8001), 5'b0, 1,
            16'h8001, 0, 1, 0);
        for (int j = 0; j < 10; j++)
            add(5'b00001, 1, d5(0, 0, 0, 0, 16'h4002), 5'b0, 0,
                16'h8001, 0, 1, 0);
        add(5'b00001, 0, d5(0, 0, 0, 0, 16'h4002), 5'b1, 0,
            16'h8001, 0, 1, 0);
        add(5'b00001, 0, d5(0, 0, 0, 0, 16'h4002), 5'b0, 0,
            16'h8001, 0, 1, 0);
        add(5'b00001, 0, d5(0, 0, 0, 0, 16'h4002), 5'b0, 1,
            16'h4002, 0, 0, 0);

        // framing: missing head, then unexpected head
        sf = tbl.size();
        add(5'b00010, 0, d5(0, 0, 0, 16'h0005, 0), 5'b00010, 0,
            16'h0000, 1, 1, 0);
        add(5'b00010, 0, d5(0, 0, 0, 16'h0005, 0), 5'b0, 0,
            16'h0000, 1, 1, 0);
        add(5'b00010, 0, d5(0, 0, 0, 16'h0005, 0), 5'b0, 1,
            16'h0005, 1, 1, 1);
        add(5'b00010, 0, d5(0, 0, 0, 16'hC006, 0), 5'b00010, 0,
            16'h0005, 1, 1, 0);
        add(5'b00010, 0, d5(0, 0, 0, 16'hC006, 0), 5'b0, 0,
            16'h0005, 1, 1, 0);
        add(5'b00010, 0, d5(0, 0, 0, 16'hC006, 0), 5'b0, 1,
            16'hC006, 1, 0, 1);
        add(5'b00000, 0, d5(0, 0, 0, 16'hC006, 0), 5'b0, 0,
            16'hC006, 1, 0, 0);
        send = tbl.size();

        do_reset();
        run(sa, sb);

        // asynchronous reset while locked on port 2
        rst = 1'b1;
        #1;
        chk_all(-2, 5'b0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run(sb, sc);

        do_reset();
        run(sc, sd);
        do_reset();
        run(sd, se);
        do_reset();
        run(se, sf);
        do_reset();
        run(sf, send);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
